// File: rtl/eq_gain_scheduler.sv
// Shadow EQ gain table with dirty tracking. Changed bands are pushed to the DSP one word per cycle
// over valid/ready. A push burst starts only on the cycle after an ADC sample-done pulse.
module eq_gain_scheduler #(
  parameter int N_BAND   = 7,
  parameter int GAIN_W   = 16,
  parameter int GAIN_MAX = 12,
  parameter int GAIN_MIN = -11
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_sample_done,
  input  logic                     i_req_valid,
  input  logic [2:0]               i_req_band,
  input  logic signed [GAIN_W-1:0] i_req_gain,
  output logic                     o_req_ready,
  input  logic                     i_clear,
  output logic                     o_cfg_valid,
  output logic [2:0]               o_cfg_band,
  output logic signed [GAIN_W-1:0] o_cfg_gain,
  input  logic                     i_cfg_ready,
  output logic [N_BAND-1:0]        o_dirty,
  output logic                     o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_PUSH} state_t;

  localparam logic signed [GAIN_W-1:0] G_MAX = GAIN_W'(GAIN_MAX);
  localparam logic signed [GAIN_W-1:0] G_MIN = GAIN_W'(GAIN_MIN);

  state_t                     state_q, state_d;
  logic signed [GAIN_W-1:0]   shadow_q [N_BAND];
  logic signed [GAIN_W-1:0]   shadow_d [N_BAND];
  logic [N_BAND-1:0]          dirty_q, dirty_d;
  logic                       rewr_q, rewr_d;
  logic                       cfg_valid_q, cfg_valid_d;
  logic [2:0]                 cfg_band_q, cfg_band_d;
  logic signed [GAIN_W-1:0]   cfg_gain_q, cfg_gain_d;
  logic                       wr_en, hs, hit_cur;
  logic signed [GAIN_W-1:0]   clamped;
  logic [2:0]                 next_band;

  function automatic logic [2:0] lowest(input logic [N_BAND-1:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = N_BAND - 1; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign o_req_ready = ~i_clear;
  assign wr_en       = i_req_valid && !i_clear && ({1'b0, i_req_band} < 4'(N_BAND));
  assign hs          = cfg_valid_q && i_cfg_ready;
  assign hit_cur     = cfg_valid_q && wr_en && (i_req_band == cfg_band_q);
  assign clamped     = (i_req_gain > G_MAX) ? G_MAX :
                       (i_req_gain < G_MIN) ? G_MIN : i_req_gain;

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    dirty_d     = dirty_q;
    rewr_d      = rewr_q;
    cfg_valid_d = cfg_valid_q;
    cfg_band_d  = cfg_band_q;
    cfg_gain_d  = cfg_gain_q;

    // A presented band rewritten or cleared before its handshake must stay dirty for a re-push.
    if (cfg_valid_q && !hs && (hit_cur || i_clear)) rewr_d = 1'b1;
    if (hs && !(rewr_q || hit_cur)) dirty_d[cfg_band_q] = 1'b0;

    for (int b = 0; b < N_BAND; b++) begin
      if (wr_en && (i_req_band == 3'(b))) begin
        shadow_d[b] = clamped;
        dirty_d[b]  = 1'b1;
      end
    end
    if (i_clear) begin
      for (int b = 0; b < N_BAND; b++) shadow_d[b] = '0;
      dirty_d = '1;
    end

    next_band = lowest(dirty_d);

    case (state_q)
      S_IDLE, S_ARM: begin
        if (i_sample_done && (dirty_q != '0)) begin
          state_d     = S_PUSH;
          cfg_valid_d = 1'b1;
          cfg_band_d  = next_band;
          cfg_gain_d  = shadow_d[next_band];
          rewr_d      = 1'b0;
        end else if (dirty_q != '0) begin
          state_d = S_ARM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PUSH: begin
        if (hs) begin
          rewr_d = 1'b0;
          if (dirty_d != '0) begin
            cfg_band_d = next_band;
            cfg_gain_d = shadow_d[next_band];
          end else begin
            cfg_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      dirty_q     <= '0;
      rewr_q      <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_band_q  <= '0;
      cfg_gain_q  <= '0;
      for (int b = 0; b < N_BAND; b++) shadow_q[b] <= '0;
    end else begin
      state_q     <= state_d;
      dirty_q     <= dirty_d;
      rewr_q      <= rewr_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_band_q  <= cfg_band_d;
      cfg_gain_q  <= cfg_gain_d;
      for (int b = 0; b < N_BAND; b++) shadow_q[b] <= shadow_d[b];
    end
  end

  assign o_cfg_valid = cfg_valid_q;
  assign o_cfg_band  = cfg_band_q;
  assign o_cfg_gain  = cfg_gain_q;
  assign o_dirty     = dirty_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_eq_gain_scheduler.sv
// Directed bench for eq_gain_scheduler: clamp table plus multi-cycle push, hold, clear and reset sequences.
module tb_eq_gain_scheduler;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               sample_done, req_valid, clear, cfg_ready;
  logic [2:0]         req_band, cfg_band;
  logic signed [15:0] req_gain, cfg_gain;
  logic               req_ready, cfg_valid, busy;
  logic [6:0]         dirty;

  int n_chk  = 0;
  int n_pass = 0;

  eq_gain_scheduler dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_sample_done (sample_done),
    .i_req_valid   (req_valid),
    .i_req_band    (req_band),
    .i_req_gain    (req_gain),
    .o_req_ready   (req_ready),
    .i_clear       (clear),
    .o_cfg_valid   (cfg_valid),
    .o_cfg_band    (cfg_band),
    .o_cfg_gain    (cfg_gain),
    .i_cfg_ready   (cfg_ready),
    .o_dirty       (dirty),
    .o_busy        (busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]         band;
    logic signed [15:0] gain;
    logic signed [15:0] exp_gain;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] b, input logic signed [15:0] g);
    req_valid = 1'b1;
    req_band  = b;
    req_gain  = g;
    step();
    req_valid = 1'b0;
  endtask

  task automatic pulse();
    sample_done = 1'b1;
    step();
    sample_done = 1'b0;
  endtask

  task automatic chk_word(input string nm, input int b, input int g);
    chk({nm, "_valid"}, int'(cfg_valid), 1);
    chk({nm, "_band"}, int'(cfg_band), b);
    chk({nm, "_gain"}, int'(cfg_gain), g);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, int'(cfg_valid), 0);
    chk({nm, "_dirty"}, int'(dirty), 0);
    chk({nm, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{3'd3, 16'sd5,      16'sd5};
    vecs[1] = '{3'd0, 16'sd12,     16'sd12};
    vecs[2] = '{3'd6, 16'sd13,     16'sd12};
    vecs[3] = '{3'd5, -16'sd11,    -16'sd11};
    vecs[4] = '{3'd1, -16'sd12,    -16'sd11};
    vecs[5] = '{3'd2, -16'sd32768, -16'sd11};
    vecs[6] = '{3'd4, 16'sd32767,  16'sd12};
    vecs[7] = '{3'd6, 16'sd0,      16'sd0};

    i_rst = 1'b1; sample_done = 0; req_valid = 0; clear = 0; cfg_ready = 1;
    req_band = '0; req_gain = '0;
    step(); step();
    i_rst = 1'b0;

    // Reset then idle
    repeat (100) step();
    chk_idle("reset_idle");
    chk("reset_req_ready", int'(req_ready), 1);

    // Clamp table: write, push on next sample, then idle again
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].band, vecs[i].gain);
      chk($sformatf("tbl%0d_dirty", i), int'(dirty), 1 << vecs[i].band);
      pulse();
      chk_word($sformatf("tbl%0d", i), int'(vecs[i].band), int'(vecs[i].exp_gain));
      step();
      chk_idle($sformatf("tbl%0d_after", i));
    end

    // Out-of-range band is discarded
    wr(3'd7, 16'sd5);
    chk("badband_dirty", int'(dirty), 0);
    step();
    chk("badband_busy", int'(busy), 0);

    // Two writes, ascending push order, ARM state seen as busy
    wr(3'd2, 16'sd40);
    wr(3'd1, -16'sd30);
    step();
    chk("arm_busy", int'(busy), 1);
    pulse();
    chk_word("two_w0", 1, -11);
    step();
    chk_word("two_w1", 2, 12);
    step();
    chk_idle("two_after");

    // Stall with rewrite of the presented band
    cfg_ready = 1'b0;
    wr(3'd4, 16'sd3);
    pulse();
    chk_word("stall_w0", 4, 3);
    wr(3'd4, 16'sd7);
    repeat (4) step();
    chk_word("stall_hold", 4, 3);
    cfg_ready = 1'b1;
    step();
    chk_word("stall_repush", 4, 7);
    step();
    chk_idle("stall_after");

    // Clear while idle with a dropped same-cycle write
    clear = 1'b1; req_valid = 1'b1; req_band = 3'd0; req_gain = 16'sd9;
    #1;
    chk("clear_req_ready", int'(req_ready), 0);
    step();
    clear = 1'b0; req_valid = 1'b0;
    chk("clear_dirty", int'(dirty), 7'h7F);
    pulse();
    for (int b = 0; b < 7; b++) begin
      chk_word($sformatf("clr_w%0d", b), b, 0);
      step();
    end
    chk_idle("clr_after");

    // Clear while a word is stalled: word held, then full re-push from band 0
    cfg_ready = 1'b0;
    wr(3'd1, 16'sd4);
    wr(3'd3, 16'sd2);
    pulse();
    chk_word("pclr_w0", 1, 4);
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    chk_word("pclr_hold", 1, 4);
    cfg_ready = 1'b1;
    step();
    for (int b = 0; b < 7; b++) begin
      chk_word($sformatf("pclr_w%0d", b), b, 0);
      step();
    end
    chk_idle("pclr_after");

    // Asynchronous reset mid-burst
    cfg_ready = 1'b0;
    wr(3'd2, 16'sd6);
    wr(3'd5, 16'sd1);
    pulse();
    chk_word("rst_w0", 2, 6);
    #2 i_rst = 1'b1;
    #1;
    chk_idle("rst_async");
    chk("rst_req_ready", int'(req_ready), 1);
    step();
    i_rst = 1'b0;
    cfg_ready = 1'b1;
    step();
    pulse();
    chk("rst_no_push", int'(cfg_valid), 0);
    step();
    chk_idle("rst_after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
